// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate extender for the ARM decode stage.
// S1 captures Instr/ImmSrc; S2 holds the extended immediate and shifter flags.
module imm_extend_pipe #(
    parameter int WIDTH  = 32,
    parameter bit ROT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [23:0]      Instr,
    input  logic [2:0]       ImmSrc,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ExtImm,
    output logic             RotCarry,
    output logic             RotCarryVld,
    output logic             Illegal
);

    typedef enum logic [2:0] {
        SRC_IMM8   = 3'b000,
        SRC_IMM12  = 3'b001,
        SRC_BRANCH = 3'b010,
        SRC_ROT    = 3'b011,
        SRC_IMM24  = 3'b100
    } imm_src_e;

    logic             s1_valid;
    logic             s2_valid;
    logic [23:0]      s1_instr;
    logic [2:0]       s1_src;
    logic             s2_adv;
    logic             take_in;

    logic [WIDTH-1:0] ext_d;
    logic             carry_d;
    logic             carry_vld_d;
    logic             illegal_d;
    logic [4:0]       rot_amt;
    logic [31:0]      rot_val;

    assign s2_adv   = !s2_valid || OutReady;
    assign InReady  = !s1_valid || s2_adv;
    assign take_in  = InValid && InReady;
    assign OutValid = s2_valid;

    // Flush outranks every advance, so an input offered alongside it is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (Flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (take_in)
                s1_valid <= 1'b1;
            else if (s2_adv)
                s1_valid <= 1'b0;
            if (s2_adv)
                s2_valid <= s1_valid;
        end
    end

    // NOTE: S1 data carries no reset; it is only ever consumed behind s1_valid.
    always_ff @(posedge clk) begin
        if (take_in) begin
            s1_instr <= Instr;
            s1_src   <= ImmSrc;
        end
    end

    // Shifting a doubled copy of the byte right yields a 32-bit rotate in one step.
    assign rot_amt = {s1_instr[11:8], 1'b0};
    assign rot_val = 32'({24'd0, s1_instr[7:0], 24'd0, s1_instr[7:0]} >> rot_amt);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ext_d       = '0;
        carry_d     = 1'b0;
        carry_vld_d = 1'b0;
        illegal_d   = 1'b0;
        case (s1_src)
            SRC_IMM8:   ext_d = WIDTH'(s1_instr[7:0]);
            SRC_IMM12:  ext_d = WIDTH'(s1_instr[11:0]);
            SRC_BRANCH: ext_d = WIDTH'($signed({s1_instr, 2'b00}));
            SRC_ROT: begin
                if (ROT_EN) begin
                    ext_d       = WIDTH'(rot_val);
                    carry_vld_d = (s1_instr[11:8] != 4'd0);
                    carry_d     = carry_vld_d && rot_val[31];
                end else begin
                    illegal_d = 1'b1;
                end
            end
            SRC_IMM24:  ext_d = WIDTH'(s1_instr);
            default:    illegal_d = 1'b1;
        endcase
    end

    // Output registers only load a real S1 entry, so bubbles leave them untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ExtImm      <= '0;
            RotCarry    <= 1'b0;
            RotCarryVld <= 1'b0;
            Illegal     <= 1'b0;
        end else if (s2_adv && s1_valid) begin
            ExtImm      <= ext_d;
            RotCarry    <= carry_d;
            RotCarryVld <= carry_vld_d;
            Illegal     <= illegal_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed plan steps plus random traffic, checked
// against an arithmetic reference model and an in-order item queue.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        Flush;
    logic        InValid;
    logic [23:0] Instr;
    logic [2:0]  ImmSrc;
    logic        OutReady;

    logic        InReady,   InReady_n;
    logic        OutValid,  OutValid_n;
    logic [31:0] ExtImm,    ExtImm_n;
    logic        RotCarry,  RotCarry_n;
    logic        RotCarryVld, RotCarryVld_n;
    logic        Illegal,   Illegal_n;

    imm_extend_pipe #(.WIDTH(32), .ROT_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
        .Instr(Instr), .ImmSrc(ImmSrc), .OutValid(OutValid), .OutReady(OutReady),
        .ExtImm(ExtImm), .RotCarry(RotCarry), .RotCarryVld(RotCarryVld), .Illegal(Illegal)
    );

    imm_extend_pipe #(.WIDTH(32), .ROT_EN(1'b0)) u_norot (
        .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady_n),
        .Instr(Instr), .ImmSrc(ImmSrc), .OutValid(OutValid_n), .OutReady(OutReady),
        .ExtImm(ExtImm_n), .RotCarry(RotCarry_n), .RotCarryVld(RotCarryVld_n), .Illegal(Illegal_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ext;
        logic        c;
        logic        cv;
        logic        ill;
    } res_t;

    typedef struct {
        logic [23:0] ins;
        logic [2:0]  src;
        bit          shown;
    } item_t;

    item_t q[$];
    int    n_vec   = 0;
    int    n_err   = 0;
    bit    rst_prev = 1'b0;

    function automatic res_t ref_model(input logic [23:0] ins, input logic [2:0] src, input bit rot_en);
        res_t            r;
        longint          s;
        longint unsigned x;
        longint unsigned full;
        int              sh;
        r = '0;
        case (src)
            3'd0: r.ext = 32'(ins % 24'd256);
            3'd1: r.ext = 32'(ins % 24'd4096);
            3'd2: begin
                s = longint'(ins);
                if (ins >= 24'h800000)
                    s = s - 64'sd16777216;
                r.ext = 32'(s * 4);
            end
            3'd3: begin
                if (rot_en) begin
                    sh    = 2 * int'(ins[11:8]);
                    x     = longint'(ins % 24'd256);
                    full  = (x >> sh) | (x << (32 - sh));
                    r.ext = 32'(full);
                    r.cv  = (sh != 0);
                    r.c   = r.cv && r.ext[31];
                end else begin
                    r.ill = 1'b1;
                end
            end
            3'd4: r.ext = 32'(ins);
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, compare just after, then advance the model
    // to the state the following rising edge produces.
    task automatic cycle(input bit v, input logic [23:0] ins, input logic [2:0] src,
                         input bit ordy, input bit fl, input bit rn, output bit acc);
        bit    exp_rdy;
        bit    exp_ov;
        res_t  e1;
        res_t  e2;
        item_t h;
        @(negedge clk);
        InValid  = v;
        Instr    = ins;
        ImmSrc   = src;
        OutReady = ordy;
        Flush    = fl;
        reset    = rn;
        #1;
        exp_rdy = (q.size() < 2) || ordy;
        exp_ov  = (q.size() > 0) && q[0].shown;
        chk("in_ready", 64'(InReady), 64'(exp_rdy));
        chk("in_ready_norot", 64'(InReady_n), 64'(exp_rdy));
        chk("out_valid", 64'(OutValid), 64'(exp_ov));
        chk("out_valid_norot", 64'(OutValid_n), 64'(exp_ov));
        if (exp_ov) begin
            e1 = ref_model(q[0].ins, q[0].src, 1'b1);
            e2 = ref_model(q[0].ins, q[0].src, 1'b0);
            chk("ext_imm", 64'(ExtImm), 64'(e1.ext));
            chk("rot_carry", 64'(RotCarry), 64'(e1.c));
            chk("rot_carry_vld", 64'(RotCarryVld), 64'(e1.cv));
            chk("illegal", 64'(Illegal), 64'(e1.ill));
            chk("ext_imm_norot", 64'(ExtImm_n), 64'(e2.ext));
            chk("rot_carry_norot", 64'(RotCarry_n), 64'(e2.c));
            chk("illegal_norot", 64'(Illegal_n), 64'(e2.ill));
        end
        if (rst_prev) begin
            chk("rst_ext", 64'(ExtImm), 64'd0);
            chk("rst_flags", 64'({RotCarry, RotCarryVld, Illegal}), 64'd0);
            chk("rst_ext_norot", 64'(ExtImm_n), 64'd0);
        end
        acc = 1'b0;
        if (!rn) begin
            q.delete();
            rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            if (fl) begin
                q.delete();
            end else begin
                if (exp_ov && ordy)
                    void'(q.pop_front());
                if (q.size() > 0 && !q[0].shown) begin
                    h       = q[0];
                    h.shown = 1'b1;
                    q[0]    = h;
                end
                if (v && exp_rdy) begin
                    h.ins   = ins;
                    h.src   = src;
                    h.shown = 1'b0;
                    q.push_back(h);
                    acc = 1'b1;
                end
            end
        end
    endtask

    task automatic single(input logic [23:0] ins, input logic [2:0] src,
                          input logic [31:0] ext, input bit c, input bit cv, input bit ill);
        bit acc;
        cycle(1'b1, ins, src, 1'b1, 1'b0, 1'b1, acc);
        cycle(1'b0, 24'd0, 3'd0, 1'b1, 1'b0, 1'b1, acc);
        cycle(1'b0, 24'd0, 3'd0, 1'b1, 1'b0, 1'b1, acc);
        chk("lat_out_valid", 64'(OutValid), 64'd1);
        chk("lat_ext", 64'(ExtImm), 64'(ext));
        chk("lat_carry", 64'({RotCarry, RotCarryVld}), 64'({c, cv}));
        chk("lat_illegal", 64'(Illegal), 64'(ill));
        if (src == 3'b011) begin
            chk("norot_ext", 64'(ExtImm_n), 64'd0);
            chk("norot_illegal", 64'(Illegal_n), 64'd1);
        end else begin
            chk("norot_ext", 64'(ExtImm_n), 64'(ext));
        end
        cycle(1'b0, 24'd0, 3'd0, 1'b1, 1'b0, 1'b1, acc);
    endtask

    initial begin
        bit          acc;
        int          n_sent;
        logic [23:0] r_ins;
        logic [2:0]  r_src;

        reset = 1'b0; Flush = 1'b0; InValid = 1'b0; Instr = '0; ImmSrc = '0; OutReady = 1'b1;

        // Reset, then one item per mode.
        cycle(1'b0, 24'd0, 3'd0, 1'b1, 1'b0, 1'b0, acc);
        cycle(1'b0, 24'd0, 3'd0, 1'b1, 1'b0, 1'b0, acc);
        cycle(1'b0, 24'd0, 3'd0, 1'b1, 1'b0, 1'b1, acc);
        chk("reset_ready", 64'(InReady), 64'd1);
        single(24'h123ABC, 3'b000, 32'h000000BC, 1'b0, 1'b0, 1'b0);
        single(24'h123ABC, 3'b001, 32'h00000ABC, 1'b0, 1'b0, 1'b0);
        single(24'h123ABC, 3'b100, 32'h00123ABC, 1'b0, 1'b0, 1'b0);
        single(24'hFFFFFE, 3'b010, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0);
        single(24'h000001, 3'b010, 32'h00000004, 1'b0, 1'b0, 1'b0);
        single(24'h0004FF, 3'b011, 32'hFF000000, 1'b1, 1'b1, 1'b0);
        single(24'h0000FF, 3'b011, 32'h000000FF, 1'b0, 1'b0, 1'b0);
        single(24'h000F01, 3'b011, 32'h00000004, 1'b0, 1'b1, 1'b0);
        single(24'h123ABC, 3'b110, 32'h00000000, 1'b0, 1'b0, 1'b1);

        // Backpressure: five items, OutReady held low for the first four cycles.
        n_sent = 0;
        r_ins  = 24'($urandom);
        r_src  = 3'($urandom_range(0, 4));
        for (int k = 0; k < 14; k++) begin
            cycle(n_sent < 5, r_ins, r_src, k >= 4, 1'b0, 1'b1, acc);
            if (k == 3) begin
                chk("bp_stall_ready", 64'(InReady), 64'd0);
                chk("bp_stall_valid", 64'(OutValid), 64'd1);
            end
            if (acc) begin
                n_sent++;
                r_ins = 24'($urandom);
                r_src = 3'($urandom_range(0, 4));
            end
        end

        // Flush with two items in flight and a third offered alongside.
        cycle(1'b1, 24'($urandom), 3'd1, 1'b1, 1'b0, 1'b1, acc);
        cycle(1'b1, 24'($urandom), 3'd4, 1'b1, 1'b0, 1'b1, acc);
        cycle(1'b1, 24'($urandom), 3'd0, 1'b0, 1'b1, 1'b1, acc);
        cycle(1'b0, 24'd0, 3'd0, 1'b1, 1'b0, 1'b1, acc);
        chk("flush_out_valid", 64'(OutValid), 64'd0);
        cycle(1'b0, 24'd0, 3'd0, 1'b1, 1'b0, 1'b1, acc);
        single(24'hABCDEF, 3'b001, 32'h00000DEF, 1'b0, 1'b0, 1'b0);

        // Mid-stream reset with a full pipeline stalled.
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 24'($urandom), 3'($urandom_range(0, 4)), 1'b0, 1'b0, 1'b1, acc);
        cycle(1'b1, 24'($urandom), 3'd2, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b0, 24'd0, 3'd0, 1'b1, 1'b0, 1'b1, acc);
        chk("mid_rst_out_valid", 64'(OutValid), 64'd0);
        chk("mid_rst_ext", 64'(ExtImm), 64'd0);
        chk("mid_rst_ready", 64'(InReady), 64'd1);
        for (int k = 0; k < 4; k++)
            cycle(1'b0, 24'd0, 3'd0, 1'b1, 1'b0, 1'b1, acc);

        // Random traffic with occasional flush and reset.
        for (int k = 0; k < 600; k++)
            cycle($urandom_range(0, 3) != 0, 24'($urandom), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                  $urandom_range(0, 80) != 0, acc);
        for (int k = 0; k < 6; k++)
            cycle(1'b0, 24'd0, 3'd0, 1'b1, 1'b0, 1'b1, acc);
        chk("drained", 64'(OutValid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Pipelined, parametrised immediate extender for the ARM datapath decode stage; successor to the single-cycle combinational extender.
- Accepts a 24-bit instruction field and an immediate-source select and produces a WIDTH-bit extended immediate.
- Adds the ARM data-processing rotated immediate, a 24-bit zero-extend mode, illegal-mode flagging, shifter carry-out, and a 2-stage valid/ready pipeline with flush.

Parameters:
- WIDTH, 32, output immediate width; legal range 26..64.
- ROT_EN, 1, 1 enables the rotated-immediate mode 3'b011; 0 makes 3'b011 illegal.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- Flush  input  1  synchronous pipeline clear.
- InValid  input  1  upstream presents Instr/ImmSrc.
- InReady  output  1  block can accept this cycle.
- Instr  input  24  instruction bits [23:0].
- ImmSrc  input  3  mode select.
- OutValid  output  1  ExtImm/flags valid.
- OutReady  input  1  downstream accepts.
- ExtImm  output  WIDTH  extended immediate.
- RotCarry  output  1  shifter carry from rotation.
- RotCarryVld  output  1  1 when rotation amount is non-zero, i.e. RotCarry is meaningful.
- Illegal  output  1  ImmSrc was undefined.

Behaviour:
- **Modes.** Computed in stage 2 from the stage-1 registered Instr/ImmSrc.
  - 000: zero-extend Instr[7:0].
  - 001: zero-extend Instr[11:0].
  - 010: sign-extend {Instr[23:0],2'b00} from bit 25 to WIDTH.
  - 011 (ROT_EN=1): zero-extend Instr[7:0] to WIDTH, then rotate right by 2*Instr[11:8] within a 32-bit field; the result is zero-extended to WIDTH when WIDTH>32. RotCarryVld = (Instr[11:8]!=0). RotCarry = result bit 31 when RotCarryVld=1, else 0.
  - 100: zero-extend Instr[23:0].
  - 101, 110, 111 (and 011 when ROT_EN=0): ExtImm=0, Illegal=1.
- **Flags outside mode 011.** RotCarry=0 and RotCarryVld=0 in every mode other than 011.
- **No X.** No X is ever driven on any output.
- **Pipeline.** Two register stages, S1 (captured inputs) and S2 (computed outputs), each with its own valid bit.
  - Latency is exactly 2 cycles from an InValid&&InReady edge to OutValid with no backpressure.
  - Throughput is 1 per cycle.
- **Handshake.**
  - S2 advances when !s2_valid || OutReady.
  - S1 advances into S2 under that same condition.
  - InReady = !s1_valid || (!s2_valid || OutReady). InReady is combinational and depends on OutReady only, never on InValid.
  - A transfer occurs on a cycle with InValid && InReady; S1 captures on that edge.
- **Holding.** While OutValid=1 and OutReady=0, ExtImm, RotCarry, RotCarryVld and Illegal are held stable. OutValid is not dropped until the transfer completes.
- **Bubbles.** When S1 is empty and S2 drains, OutValid falls on the next cycle. Bubbles never produce OutValid.
- **Flush.**
  - Flush=1 on a clock edge clears s1_valid and s2_valid.
  - An input offered in the same cycle is discarded, even if InValid && InReady.
  - Flush takes priority over all advances.
  - During Flush, InReady reflects the normal equation; the discard is internal.
- **Reset.** When reset=0 at a clock edge, all of the following are 0:
  - s1_valid, s2_valid
  - OutValid
  - ExtImm
  - RotCarry, RotCarryVld
  - Illegal

  InReady=1 while the pipeline is empty after reset. Reset mid-stream drops all in-flight entries; no output appears for them.
- **Simultaneous events.**
  - Full pipeline with OutReady=1 and InValid=1: S2 outputs, S1 moves to S2, and the new input enters S1, all in one edge.
  - Full pipeline with OutReady=0: InReady=0 and no state changes.
- **Data registers.** Data registers update only when their stage advances; they are not reset-gated otherwise.

Test Plan:
- **Reset, then single transfers.** Apply reset, release it, then send one item per mode with Instr=24'h123ABC. Required on OutValid, 2 cycles later (WIDTH=32):
  - mode 000 -> 32'h000000BC
  - mode 001 -> 32'h00000ABC
  - mode 100 -> 32'h00123ABC
  - Illegal=0 for all three.
- **Branch.** Instr=24'hFFFFFE, mode 010 -> 32'hFFFFFFF8. Instr=24'h000001 -> 32'h00000004.
- **Rotate.**
  - Instr=24'h0004FF, mode 011 -> ExtImm=32'hFF000000, RotCarry=1, RotCarryVld=1.
  - Instr=24'h0000FF -> 32'h000000FF, RotCarryVld=0.
  - Instr=24'h000F01 -> 32'h00000004, RotCarry=0.
  - With ROT_EN=0, mode 011 -> ExtImm=0, Illegal=1.
- **Backpressure.** Stream 5 back-to-back items while holding OutReady=0 for 4 cycles. Required:
  - InReady=0 once both stages are full.
  - Outputs stay stable during the stall.
  - All 5 items emerge in order with no loss or duplication.
  - Full throughput resumes once OutReady=1.
- **Flush.** With 2 items in flight, assert Flush together with InValid=1. Required:
  - OutValid=0 on the next cycle.
  - None of those 3 items is ever output.
  - The next accepted item emerges 2 cycles later.
- **Mid-stream reset.** Pull reset low while the pipeline is full and OutReady=0. Required after the reset edge:
  - OutValid=0 and ExtImm=0.
  - InReady=1.
  - No stale item appears after reset is released.
